sram_fill_drain: RTL

SRAM_FILL_DRAIN -- requirements
Module: sram_fill_drain

---
 rtl/sram_fill_drain.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/sram_fill_drain.sv
// ---------------------------------------------------------------------------
// sram_fill_drain
//   Buffers one frame from an input stream into an external single-port RAM
//   (FILL). It then streams the frame back out through a two-entry skid FIFO
//   (DRAIN). The RAM has a registered read, so read data appears one cycle
//   after the read was issued.
//
//   Optional macro: SRAM_FILL_DRAIN_REVERSE_EN
//     When defined, DRAIN reads addresses len-1 down to 0 (LIFO order).
//     When undefined, DRAIN reads addresses 0 up to len-1 (FIFO order).
//
// Ports
//   clk, rst                  single clock; synchronous active-high reset
//   in_valid/in_ready/in_data/in_last      input stream
//   ram_ce/ram_we/ram_addr/ram_data/ram_q  RAM port (ram_q: registered read)
//   out_valid/out_ready/out_data/out_last  output stream
// ---------------------------------------------------------------------------
module sram_fill_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int RAM_DEPTH  = 4,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  ram_ce,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  // Counters need one extra bit so they can hold len == RAM_DEPTH.
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                  state_q,         state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q,        wr_ptr_d;
  logic [CW-1:0]           len_q,           len_d;
  logic [CW-1:0]           rd_cnt_q,        rd_cnt_d;        // reads issued
  logic                    inflight_q,      inflight_d;      // read issued last cycle
  logic                    inflight_last_q, inflight_last_d; // that read is the frame's last word
  logic [1:0]              skid_cnt_q,      skid_cnt_d;
  logic [DATA_WIDTH-1:0]   skid0_data_q,    skid0_data_d;    // head entry
  logic                    skid0_last_q,    skid0_last_d;
  logic [DATA_WIDTH-1:0]   skid1_data_q,    skid1_data_d;
  logic                    skid1_last_q,    skid1_last_d;

  logic       pop;
  logic       push;
  logic       issue;
  logic [1:0] occ_after;

  // Outputs come straight from the skid registers.
  assign out_valid = (skid_cnt_q != 2'd0);
  assign out_data  = skid0_data_q;
  assign out_last  = skid0_last_q && out_valid;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    len_d           = len_q;
    rd_cnt_d        = rd_cnt_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    skid_cnt_d      = skid_cnt_q;
    skid0_data_d    = skid0_data_q;
    skid0_last_d    = skid0_last_q;
    skid1_data_d    = skid1_data_q;
    skid1_last_d    = skid1_last_q;
    in_ready        = 1'b0;
    ram_ce          = 1'b0;
    ram_we          = 1'b0;
    ram_addr        = '0;
    ram_data        = '0;
    issue           = 1'b0;

    pop  = out_valid && out_ready;
    push = inflight_q;
    // Occupancy the skid will have once this cycle's pop retires, counting the
    // read whose data is on ram_q now. Crediting the pop keeps one word per
    // cycle flowing; without it every other cycle would bubble.
    occ_after = skid_cnt_q + 2'(inflight_q) - 2'(pop);

    unique case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ram_ce   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = wr_ptr_q;
          ram_data = in_data;
          // The top address ends the frame even without in_last, so the
          // write pointer never wraps.
          if (in_last || (wr_ptr_q == LAST_ADDR)) begin
            state_d  = DRAIN;
            len_d    = CW'(wr_ptr_q) + CW'(1);
            wr_ptr_d = '0;
            rd_cnt_d = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        issue = (rd_cnt_q < len_q) && (occ_after < 2'd2);
        if (issue) begin
          ram_ce = 1'b1;
`ifdef SRAM_FILL_DRAIN_REVERSE_EN
          ram_addr = ADDR_WIDTH'(len_q - rd_cnt_q - CW'(1));
`else
          ram_addr = ADDR_WIDTH'(rd_cnt_q);
`endif
          rd_cnt_d        = rd_cnt_q + CW'(1);
          inflight_d      = 1'b1;
          inflight_last_d = (rd_cnt_q == len_q - CW'(1));
        end
      end
      default: ;
    endcase

    // Skid FIFO: entry 0 is always the head, entry 1 the tail.
    // Issue throttling guarantees no push when full and no pop when empty.
    unique case ({push, pop})
      2'b10: begin
        if (skid_cnt_q == 2'd0) begin
          skid0_data_d = ram_q;
          skid0_last_d = inflight_last_q;
        end else begin
          skid1_data_d = ram_q;
          skid1_last_d = inflight_last_q;
        end
        skid_cnt_d = skid_cnt_q + 2'd1;
      end
      2'b01: begin
        skid0_data_d = skid1_data_q;
        skid0_last_d = skid1_last_q;
        skid_cnt_d   = skid_cnt_q - 2'd1;
      end
      2'b11: begin
        if (skid_cnt_q == 2'd1) begin
          skid0_data_d = ram_q;
          skid0_last_d = inflight_last_q;
        end else begin
          skid0_data_d = skid1_data_q;
          skid0_last_d = skid1_last_q;
          skid1_data_d = ram_q;
          skid1_last_d = inflight_last_q;
        end
      end
      default: ;
    endcase

    // Handshake of the frame's last word: the skid holds nothing else and no
    // read is outstanding, so start the next frame from a clean slate.
    if (pop && skid0_last_q) begin
      state_d      = FILL;
      wr_ptr_d     = '0;
      len_d        = '0;
      rd_cnt_d     = '0;
      inflight_d   = 1'b0;
      skid_cnt_d   = 2'd0;
      skid0_data_d = '0;
      skid0_last_d = 1'b0;
      skid1_data_d = '0;
      skid1_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the skid entries are ordinary registers and are cleared here so
      // out_data reads 0 after reset. The RAM contents live outside this block
      // and are deliberately left alone.
      state_q         <= FILL;
      wr_ptr_q        <= '0;
      len_q           <= '0;
      rd_cnt_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      skid_cnt_q      <= 2'd0;
      skid0_data_q    <= '0;
      skid0_last_q    <= 1'b0;
      skid1_data_q    <= '0;
      skid1_last_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values computed above, independent of statement order.
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      len_q           <= len_d;
      rd_cnt_q        <= rd_cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      skid_cnt_q      <= skid_cnt_d;
      skid0_data_q    <= skid0_data_d;
      skid0_last_q    <= skid0_last_d;
      skid1_data_q    <= skid1_data_d;
      skid1_last_q    <= skid1_last_d;
    end
  end

endmodule
